// File: rtl/vliw_scoreboard_pkg.sv
// Shared constants and flattened-port slicing helpers for the VLIW scoreboard.
// Imported by the interface, the per-register entry and the top.
package vliw_pkg;

  localparam int NUM_SLOTS_D = 2;
  localparam int NUM_REGS_D  = 8;
  localparam int MAX_LAT_D   = 3;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_RF = 0;

  // Low bit of field idx in a vector packed as equal-width w fields.
  function automatic int slice_lo(int idx, int w);
    return idx * w;
  endfunction

  // Flat index of source k (0/1) belonging to slot s.
  function automatic int src_idx(int s, int k);
    return 2 * s + k;
  endfunction

endpackage

// File: rtl/vliw_scoreboard_if.sv
// Bundle/forwarding bus between the ID-stage decoder and the scoreboard.
// The decoder is the master; the scoreboard is the slave.
interface vliw_scoreboard_if #(
  parameter int NUM_SLOTS = vliw_pkg::NUM_SLOTS_D,
  parameter int NUM_REGS  = vliw_pkg::NUM_REGS_D,
  parameter int MAX_LAT   = vliw_pkg::MAX_LAT_D
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int SEL_W = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0]         slot_valid;
  logic [NUM_SLOTS-1:0]         slot_wen;
  logic [NUM_SLOTS*REG_W-1:0]   slot_rd;
  logic [NUM_SLOTS*LAT_W-1:0]   slot_lat;
  logic [NUM_SLOTS*2*REG_W-1:0] src_reg;
  logic [NUM_SLOTS*2-1:0]       src_use;
  logic                         flush;
  logic                         stall;
  logic                         issue_fire;
  logic [NUM_SLOTS*2*SEL_W-1:0] fwd_sel;
  logic [NUM_REGS-1:0]          busy;

  modport master (
    output slot_valid, slot_wen, slot_rd, slot_lat, src_reg, src_use, flush,
    input  stall, issue_fire, fwd_sel, busy
  );

  modport slave (
    input  slot_valid, slot_wen, slot_rd, slot_lat, src_reg, src_use, flush,
    output stall, issue_fire, fwd_sel, busy
  );

endinterface

// File: rtl/vliw_scoreboard_reg_entry.sv
// Pending-write state for one architectural register: countdown to bypass,
// producing slot, and the busy / not-yet-on-bypass / bypass-select flags.
module sb_reg_entry
  import vliw_pkg::*;
#(
  parameter int LAT_W = 2,
  parameter int ID_W  = 1,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  input  logic [ID_W-1:0]  set_slot,
  output logic [LAT_W-1:0] cnt,
  output logic             busy,
  output logic             pending,
  output logic [SEL_W-1:0] fwd
);

  logic [ID_W-1:0] prod;

  // NOTE: state uses non-blocking assignments so every entry samples the
  // pre-edge bundle; a new write takes priority over the decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      prod <= '0;
    end else if (set) begin
      cnt  <= set_lat;
      prod <= set_slot;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy    = (cnt != '0);
  assign pending = (cnt > LAT_W'(1));
  assign fwd     = (cnt == LAT_W'(1)) ? SEL_W'(prod) + SEL_W'(1) : SEL_W'(FWD_RF);

endmodule

// File: rtl/vliw_scoreboard.sv
// Hazard and forwarding unit for an N-slot VLIW bundle: stalls the whole
// bundle on RAW/WAW hazards and picks a bypass slot for every source operand.
module vliw_scoreboard
  import vliw_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_D,
  parameter int NUM_REGS  = NUM_REGS_D,
  parameter int MAX_LAT   = MAX_LAT_D
) (
  input logic               clk,
  input logic               reset,
  vliw_scoreboard_if.slave  bus
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int SEL_W = $clog2(NUM_SLOTS + 1);
  localparam int ID_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CMP_W = LAT_W + 1;
  localparam int NSRC  = 2 * NUM_SLOTS;

  logic [REG_W-1:0] rd  [NUM_SLOTS];
  logic [LAT_W-1:0] lat [NUM_SLOTS];
  logic [REG_W-1:0] src [NSRC];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign rd[s]  = bus.slot_rd[slice_lo(s, REG_W) +: REG_W];
    assign lat[s] = bus.slot_lat[slice_lo(s, LAT_W) +: LAT_W];

    property p_legal_lat;
      @(posedge clk) disable iff (!reset)
        (bus.slot_valid[s] && bus.slot_wen[s]) |->
          (lat[s] != '0 && int'(lat[s]) <= MAX_LAT);
    endproperty
    a_legal_lat: assert property (p_legal_lat);
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src[i] = bus.src_reg[slice_lo(i, REG_W) +: REG_W];
  end

  // Per-register state.
  logic [LAT_W-1:0]    cnt      [NUM_REGS];
  logic [SEL_W-1:0]    fwd      [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] busy_v;
  logic [NUM_REGS-1:0] set;
  logic [LAT_W-1:0]    set_lat  [NUM_REGS];
  logic [ID_W-1:0]     set_slot [NUM_REGS];

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    sb_reg_entry #(
      .LAT_W (LAT_W),
      .ID_W  (ID_W),
      .SEL_W (SEL_W)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .set      (set[r]),
      .set_lat  (set_lat[r]),
      .set_slot (set_slot[r]),
      .cnt      (cnt[r]),
      .busy     (busy_v[r]),
      .pending  (pending[r]),
      .fwd      (fwd[r])
    );
  end

  logic any_valid;
  logic raw;
  logic waw;
  logic fire;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int k = 0; k < 2; k++) begin
        if (bus.slot_valid[s] && bus.src_use[src_idx(s, k)] && pending[src[src_idx(s, k)]])
          raw = 1'b1;
      end
      // An older, slower write must retire before a newer, faster one.
      if (bus.slot_valid[s] && bus.slot_wen[s] &&
          CMP_W'(cnt[rd[s]]) > CMP_W'(lat[s]) + CMP_W'(1))
        waw = 1'b1;
    end
  end

  assign any_valid = |bus.slot_valid;
  assign bus.stall = any_valid && (raw || waw);
  assign fire      = any_valid && !bus.stall && !bus.flush;
  assign bus.issue_fire = fire;
  assign bus.busy       = busy_v;

  // Highest-numbered slot wins when several slots of a bundle write one register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      set[r]      = 1'b0;
      set_lat[r]  = '0;
      set_slot[r] = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (fire && bus.slot_valid[s] && bus.slot_wen[s] && rd[s] == REG_W'(r)) begin
          set[r]      = 1'b1;
          set_lat[r]  = lat[s];
          set_slot[r] = ID_W'(s);
        end
      end
    end
  end

  logic [NSRC*SEL_W-1:0] fwd_flat;

  always_comb begin
    fwd_flat = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.src_use[i])
        fwd_flat[slice_lo(i, SEL_W) +: SEL_W] = fwd[src[i]];
    end
  end

  assign bus.fwd_sel = fwd_flat;

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed bench for vliw_scoreboard: reset, RAW stall/bypass, single-cycle
// bypass, WAW, same-bundle double write, flush and mid-operation reset.
module tb_vliw_scoreboard;
  import vliw_pkg::*;

  localparam int NS    = 2;
  localparam int NR    = 8;
  localparam int ML    = 3;
  localparam int REG_W = 3;
  localparam int LAT_W = 2;
  localparam int SEL_W = 2;
  localparam int RD_W  = NS * REG_W;
  localparam int LT_W  = NS * LAT_W;
  localparam int SR_W  = NS * 2 * REG_W;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  vliw_scoreboard_if #(.NUM_SLOTS(NS), .NUM_REGS(NR), .MAX_LAT(ML)) bus ();

  vliw_scoreboard #(.NUM_SLOTS(NS), .NUM_REGS(NR), .MAX_LAT(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_bundle();
    bus.slot_valid = '0;
    bus.slot_wen   = '0;
    bus.slot_rd    = '0;
    bus.slot_lat   = '0;
    bus.src_reg    = '0;
    bus.src_use    = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic put_write(input int s, input int r, input int l);
    bus.slot_valid[s] = 1'b1;
    bus.slot_wen[s]   = 1'b1;
    bus.slot_rd[s*REG_W +: REG_W]  = REG_W'(r);
    bus.slot_lat[s*LAT_W +: LAT_W] = LAT_W'(l);
  endtask

  task automatic put_read(input int s, input int k, input int r);
    bus.slot_valid[s]      = 1'b1;
    bus.src_use[2*s+k]     = 1'b1;
    bus.src_reg[(2*s+k)*REG_W +: REG_W] = REG_W'(r);
  endtask

  function automatic logic [SEL_W-1:0] fsel(input int i);
    return bus.fwd_sel[i*SEL_W +: SEL_W];
  endfunction

  initial begin
    reset = 1'b0;
    clear_bundle();

    // Reset held with random inputs: all state outputs must stay quiet.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.slot_valid = NS'($urandom);
      bus.slot_wen   = NS'($urandom);
      bus.slot_rd    = RD_W'($urandom);
      bus.slot_lat   = LT_W'($urandom);
      bus.src_reg    = SR_W'($urandom);
      bus.src_use    = (2*NS)'($urandom);
      bus.flush      = 1'($urandom);
      #1;
      check("rst_stall", 32'(bus.stall), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_fwd", 32'(bus.fwd_sel), 0);
    end
    @(negedge clk);
    clear_bundle();
    reset = 1'b1;
    #1;
    check("rel_fire", 32'(bus.issue_fire), 0);
    check("rel_stall", 32'(bus.stall), 0);

    // RAW: r3 written with latency 3 -> reader stalls while cnt > 1.
    @(negedge clk); clear_bundle(); put_write(1, 3, 3); #1;
    check("raw_wr_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); put_read(0, 0, 3); #1;
    check("raw_stall_c3", 32'(bus.stall), 1);
    check("raw_nofire", 32'(bus.issue_fire), 0);
    check("raw_busy", 32'(bus.busy), 32'h08);
    @(negedge clk); #1;
    check("raw_stall_c2", 32'(bus.stall), 1);
    @(negedge clk); #1;
    check("raw_go", 32'(bus.stall), 0);
    check("raw_fwd", 32'(fsel(0)), 2);
    check("raw_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); #1;
    check("raw_fwd_rf", 32'(fsel(0)), 0);
    check("raw_busy_clr", 32'(bus.busy), 0);

    // Single-cycle bypass from slot 0.
    @(negedge clk); clear_bundle(); put_write(0, 2, 1); #1;
    check("byp_wr_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); put_read(1, 0, 2); #1;
    check("byp_stall", 32'(bus.stall), 0);
    check("byp_fwd", 32'(fsel(2)), 1);
    check("byp_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); #1;
    check("byp_busy_clr", 32'(bus.busy), 0);

    // WAW: slower older write to r5 holds back a faster newer one.
    @(negedge clk); clear_bundle(); put_write(1, 5, 3); #1;
    check("waw_wr_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); put_write(0, 5, 1); #1;
    check("waw_stall", 32'(bus.stall), 1);
    check("waw_nofire", 32'(bus.issue_fire), 0);
    @(negedge clk); #1;
    check("waw_go", 32'(bus.stall), 0);
    check("waw_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); put_read(1, 1, 5); #1;
    check("waw_fwd", 32'(fsel(3)), 1);
    check("waw_busy", 32'(bus.busy), 32'h20);
    check("waw_rd_stall", 32'(bus.stall), 0);
    @(negedge clk); clear_bundle(); #1;
    check("waw_busy_clr", 32'(bus.busy), 0);

    // Same-bundle double write to r4: slot 1 wins.
    @(negedge clk); clear_bundle(); put_write(0, 4, 2); put_write(1, 4, 1); #1;
    check("dbl_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); put_read(0, 1, 4); #1;
    check("dbl_fwd", 32'(fsel(1)), 2);
    check("dbl_stall", 32'(bus.stall), 0);
    check("dbl_busy", 32'(bus.busy), 32'h10);

    // Flush: bundle writing r6 is killed, in-flight r1 keeps counting.
    @(negedge clk); clear_bundle(); put_write(0, 1, 3); #1;
    check("fl_wr_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); put_write(1, 6, 2); bus.flush = 1'b1; #1;
    check("fl_nofire", 32'(bus.issue_fire), 0);
    check("fl_stall", 32'(bus.stall), 0);
    @(negedge clk); clear_bundle(); #1;
    check("fl_busy_c2", 32'(bus.busy), 32'h02);
    @(negedge clk); #1;
    check("fl_busy_c1", 32'(bus.busy), 32'h02);
    @(negedge clk); #1;
    check("fl_busy_c0", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a pending write.
    @(negedge clk); clear_bundle(); put_write(0, 7, 3); #1;
    check("mr_wr_fire", 32'(bus.issue_fire), 1);
    @(negedge clk); clear_bundle(); #1;
    check("mr_busy", 32'(bus.busy), 32'h80);
    #2 reset = 1'b0;
    #1;
    check("mr_busy_clr", 32'(bus.busy), 0);
    @(negedge clk); reset = 1'b1; #1;
    check("mr_after_busy", 32'(bus.busy), 0);
    check("mr_after_stall", 32'(bus.stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
